// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer: frames of WIDTH bits, selectable bit order,
// single-entry output register with valid/ready handshake and a sticky overrun flag.
module shift_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             shift,
  input  logic             sdi,
  input  logic             dir,
  input  logic             ready,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] shifted;
  logic             word_done;
  logic             handshake;

  // dir_q = 1 shifts right (LSB-first), so the first received bit ends up in bit 0.
  assign shifted   = dir_q ? {sdi, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], sdi};
  assign handshake = valid_q & ready;

  // NOTE: every variable gets a default at the top of the block; a path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    dir_d     = dir_q;
    word_done = 1'b0;

    if (start) begin
      // Same action from IDLE and as a mid-frame restart; shift is ignored.
      state_d = ST_SHIFT;
      cnt_d   = '0;
      sreg_d  = '0;
      dir_d   = dir;
    end else if (state_q == ST_SHIFT && shift) begin
      sreg_d = shifted;
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        word_done = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (word_done) begin
      if (!valid_q || ready) begin
        data_d  = shifted;
        valid_d = 1'b1;
        if (handshake) ovr_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (handshake) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; all registers here are plain flops, so each one is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      dir_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign busy     = (state_q == ST_SHIFT);
  assign overrun  = ovr_q;

endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, which sets the word width in bits; legal range is 2..32.
REQ-002 clk  input  1  rising-edge clock; the block SHALL use this single clock for all sequential logic.
REQ-003 rst_n  input  1  reset; it SHALL be asynchronous and active-low.
REQ-004 start  input  1  frame start pulse; it SHALL begin a new word frame.
REQ-005 shift  input  1  bit strobe; sdi SHALL be sampled on each clk edge where shift=1 during a frame.
REQ-006 sdi  input  1  serial data in.
REQ-007 dir  input  1  bit order: 0 = MSB-first (shift left, sdi enters bit 0); 1 = LSB-first (shift right, sdi enters bit WIDTH-1).
REQ-008 ready  input  1  consumer accepts data_out.
REQ-009 data_out  output  WIDTH  last completed word, registered.
REQ-010 valid  output  1  data_out holds an unconsumed word.
REQ-011 busy  output  1  a frame is in progress (state SHIFT).
REQ-012 overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-013 The block SHALL implement two states, IDLE and SHIFT; busy SHALL equal (state==SHIFT).
REQ-014 In IDLE, a clk edge with start=1 SHALL enter SHIFT, clear the bit counter and clear the internal shift register to 0.
REQ-015 dir SHALL be latched on the edge that accepts start, and the latched value SHALL govern the whole frame; changes to dir mid-frame SHALL be ignored.
REQ-016 In SHIFT, each edge with shift=1 and start=0 SHALL shift in sdi per the latched dir and increment the counter; edges with shift=0 SHALL hold the register and counter.
REQ-017 shift=1 in IDLE SHALL be ignored.
REQ-018 start=1 in SHIFT SHALL restart the frame: it SHALL discard the partial word, clear the counter, re-latch dir, remain in SHIFT, and ignore shift on that edge.
REQ-019 On the edge that samples bit number WIDTH, the block SHALL return to IDLE and offer the completed word, including that last bit, to the output stage on the same edge (zero extra latency).
REQ-020 Output stage: if valid=0, or if valid=1 and ready=1 on the same edge, data_out SHALL load the new word and valid SHALL be 1 after that edge.
REQ-021 Output stage: if valid=1 and ready=0 when a word completes, data_out SHALL be held, the new word SHALL be dropped, and overrun SHALL be set to 1.
REQ-022 With no word completing, an edge with valid=1 and ready=1 SHALL clear valid, and data_out SHALL retain its value.
REQ-023 overrun SHALL be cleared on a valid&ready handshake edge unless a drop also occurs on that edge; set SHALL take priority over clear.
REQ-024 ready with valid=0 SHALL have no effect.
REQ-025 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never exceed WIDTH.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force: state=IDLE, counter=0, shift register=0, data_out=0, valid=0, busy=0, overrun=0, latched dir=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial word; after rst_n rises, the block SHALL require a new start before sampling any bits.
REQ-028 The first active edge after rst_n deasserts SHALL be able to accept start.

Verification (WIDTH=8)
REQ-029 Scenario MSB-first: start with dir=0, then sdi=1,0,1,0,1,0,1,0 on 8 consecutive shift edges -> data_out=8'hAA and valid=1 after the 8th edge; busy=0 after that edge.
REQ-030 Scenario LSB-first with gaps: dir=1, sdi=0,1,0,1,0,1,0,1 with a shift=0 cycle between each bit, dir toggled mid-frame -> data_out=8'hAA, and no early valid.
REQ-031 Scenario overrun: frame 8'h3C completes with ready=0, then frame 8'hC3 completes -> data_out stays 8'h3C and overrun=1; ready pulse -> valid=0 and overrun=0.
REQ-032 Scenario back-to-back: ready held at 1 and the completion of frame 8'h5A coincides with the handshake of the prior word -> data_out=8'h5A, valid stays 1, overrun=0.
REQ-033 Scenario restart: 3 bits shifted, then start, then 8 bits of 8'h0F MSB-first -> data_out=8'h0F.
REQ-034 Scenario reset mid-frame: rst_n pulsed low after 5 bits -> all outputs 0 immediately, and 3 further shift pulses without start leave valid=0 and busy=0.
